unified_mem_arbiter: RTL and testbench

- Sequences one single-port synchronous data/program memory and shares it between three requesters:
  - instruction fetch (if)
  - load/store unit (ls)
  - debug/program loader (dbg)
- Fixed priority: dbg > ls > if, with a starvation guard that protects fetch.
- One access in flight at a time. Read responses are timed to the memory read latency.
- Sits between the CPU pipeline (plus loader) and the memory macro. It replaces the dual-port arrangement when only one port is available.

---
 rtl/unified_mem_arbiter_if.sv | 53 +++++
 rtl/unified_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of requester handshakes (fetch, load/store, debug) and the single-port memory bus
// shared by unified_mem_arbiter.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
);
   localparam int BW = DATA_WIDTH / 8;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;

   logic                  ls_req;
   logic [BW-1:0]         ls_we;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [DATA_WIDTH-1:0] ls_wdata;
   logic                  ls_gnt;
   logic                  ls_rvalid;

   logic                  dbg_req;
   logic [BW-1:0]         dbg_we;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0] dbg_wdata;
   logic                  dbg_gnt;
   logic                  dbg_rvalid;

   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic [1:0]            owner;

   logic                  mem_en;
   logic [BW-1:0]         mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      output if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
      output rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requesters plus memory macro side
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
      input  rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between fetch, load/store and debug requesters.
// Fixed priority dbg > ls > if, with fetch promoted above ls after STARVE_LIMIT starved cycles.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH   = 13,
   parameter int DATA_WIDTH   = 32,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 8
) (
   input logic                 sysclk,
   input logic                 rst,
   unified_mem_arbiter_if.slave bus
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
   localparam logic [1:0] LatInit = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

   localparam logic [1:0] OwnNone = 2'd0;
   localparam logic [1:0] OwnIf   = 2'd1;
   localparam logic [1:0] OwnLs   = 2'd2;
   localparam logic [1:0] OwnDbg  = 2'd3;

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [1:0]    lat_cnt;
   logic [1:0]    win;
   logic          resp_next;

   always_comb begin
      win = OwnNone;
      if (bus.dbg_req)                                win = OwnDbg;
      else if (bus.if_req && starve_cnt == StarveMax) win = OwnIf;
      else if (bus.ls_req)                            win = OwnLs;
      else if (bus.if_req)                            win = OwnIf;
   end

   // Read data lands in the cycle after the last latency cycle; rvalid is registered into it.
   assign resp_next = (state == StAccess && bus.mem_we == '0 && RD_LATENCY == 1) ||
                      (state == StWait && lat_cnt == 2'd0);

   assign bus.busy  = (state != StIdle);
   assign bus.rdata = bus.mem_rdata;

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state          <= StIdle;
         starve_cnt     <= '0;
         lat_cnt        <= '0;
         bus.owner      <= OwnNone;
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= '0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.if_gnt     <= 1'b0;
         bus.ls_gnt     <= 1'b0;
         bus.dbg_gnt    <= 1'b0;
         bus.if_rvalid  <= 1'b0;
         bus.ls_rvalid  <= 1'b0;
         bus.dbg_rvalid <= 1'b0;
      end else begin
         bus.if_gnt     <= 1'b0;
         bus.ls_gnt     <= 1'b0;
         bus.dbg_gnt    <= 1'b0;
         bus.if_rvalid  <= resp_next && bus.owner == OwnIf;
         bus.ls_rvalid  <= resp_next && bus.owner == OwnLs;
         bus.dbg_rvalid <= resp_next && bus.owner == OwnDbg;

         if (!bus.if_req || (state == StIdle && win == OwnIf)) begin
            starve_cnt <= '0;
         end else if (starve_cnt != StarveMax) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         case (state)
            StIdle: begin
               if (win != OwnNone) begin
                  state      <= StAccess;
                  bus.mem_en <= 1'b1;
                  bus.owner  <= win;
                  case (win)
                     OwnDbg: begin
                        bus.dbg_gnt   <= 1'b1;
                        bus.mem_addr  <= bus.dbg_addr;
                        bus.mem_we    <= bus.dbg_we;
                        bus.mem_wdata <= bus.dbg_wdata;
                     end
                     OwnLs: begin
                        bus.ls_gnt    <= 1'b1;
                        bus.mem_addr  <= bus.ls_addr;
                        bus.mem_we    <= bus.ls_we;
                        bus.mem_wdata <= bus.ls_wdata;
                     end
                     default: begin
                        bus.if_gnt    <= 1'b1;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_we    <= '0;
                     end
                  endcase
               end
            end
            StAccess: begin
               bus.mem_en <= 1'b0;
               bus.mem_we <= '0;
               if (bus.mem_we != '0) begin
                  state     <= StIdle;
                  bus.owner <= OwnNone;
               end else if (RD_LATENCY > 1) begin
                  state   <= StWait;
                  lat_cnt <= LatInit;
               end else begin
                  state <= StResp;
               end
            end
            StWait: begin
               if (lat_cnt == 2'd0) state <= StResp;
               else                 lat_cnt <= lat_cnt - 1'b1;
            end
            default: begin
               state     <= StIdle;
               bus.owner <= OwnNone;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: instance a uses RD_LATENCY=1, instance b uses RD_LATENCY=3; each has its own
// behavioural single-port memory.
module tb_unified_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus_a ();
   unified_mem_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus_b ();

   unified_mem_arbiter #(
      .ADDR_WIDTH(13), .DATA_WIDTH(32), .RD_LATENCY(1), .STARVE_LIMIT(8)
   ) dut_a (
      .sysclk(clk), .rst(rst), .bus(bus_a)
   );

   unified_mem_arbiter #(
      .ADDR_WIDTH(13), .DATA_WIDTH(32), .RD_LATENCY(3), .STARVE_LIMIT(8)
   ) dut_b (
      .sysclk(clk), .rst(rst), .bus(bus_b)
   );

   logic [31:0] mem_a [0:8191];
   logic [31:0] mem_b [0:8191];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b0, pipe_b1, pipe_b2;

   assign bus_a.mem_rdata = pipe_a;
   assign bus_b.mem_rdata = pipe_b2;

   initial begin
      for (int i = 0; i < 8192; i++) mem_a[i] = '0;
      mem_a[16] = 32'hDEADBEEF;
      mem_a[32] = 32'hAABBCCDD;
      pipe_a = '0;
      forever begin
         @(posedge clk);
         if (bus_a.mem_en) begin
            if (bus_a.mem_we != '0) begin
               for (int i = 0; i < 4; i++)
                  if (bus_a.mem_we[i]) mem_a[bus_a.mem_addr][8*i +: 8] <= bus_a.mem_wdata[8*i +: 8];
            end else begin
               pipe_a <= mem_a[bus_a.mem_addr];
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 8192; i++) mem_b[i] = '0;
      mem_b[64] = 32'h0BADF00D;
      pipe_b0 = '0;
      pipe_b1 = '0;
      pipe_b2 = '0;
      forever begin
         @(posedge clk);
         if (bus_b.mem_en && bus_b.mem_we == '0) pipe_b0 <= mem_b[bus_b.mem_addr];
         pipe_b1 <= pipe_b0;
         pipe_b2 <= pipe_b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] outs_b();
      return {bus_b.busy, bus_b.owner, bus_b.mem_en, bus_b.mem_we, bus_b.if_gnt, bus_b.ls_gnt,
              bus_b.dbg_gnt, bus_b.if_rvalid, bus_b.ls_rvalid, bus_b.dbg_rvalid};
   endfunction

   task automatic idle_inputs();
      bus_a.if_req = 0; bus_a.if_addr = '0;
      bus_a.ls_req = 0; bus_a.ls_we = '0; bus_a.ls_addr = '0; bus_a.ls_wdata = '0;
      bus_a.dbg_req = 0; bus_a.dbg_we = '0; bus_a.dbg_addr = '0; bus_a.dbg_wdata = '0;
      bus_b.if_req = 0; bus_b.if_addr = '0;
      bus_b.ls_req = 0; bus_b.ls_we = '0; bus_b.ls_addr = '0; bus_b.ls_wdata = '0;
      bus_b.dbg_req = 0; bus_b.dbg_we = '0; bus_b.dbg_addr = '0; bus_b.dbg_wdata = '0;
   endtask

   initial begin
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outs_b", 64'(outs_b()), 64'h0);
      check("rst_addr_a", 64'(bus_a.mem_addr), 64'h0);
      check("rst_starve_a", 64'(dut_a.starve_cnt), 64'h0);
      tick();
      rst = 1'b1;

      // Single fetch read, latency 1
      tick();
      bus_a.if_req = 1; bus_a.if_addr = 13'h010;
      tick();
      bus_a.if_req = 0;
      @(negedge clk);
      check("t1_if_gnt", 64'(bus_a.if_gnt), 64'h1);
      check("t1_mem_en", 64'(bus_a.mem_en), 64'h1);
      check("t1_mem_addr", 64'(bus_a.mem_addr), 64'h010);
      check("t1_owner", 64'(bus_a.owner), 64'h1);
      tick();
      @(negedge clk);
      check("t1_rvalid", 64'(bus_a.if_rvalid), 64'h1);
      check("t1_rdata", 64'(bus_a.rdata), 64'hDEADBEEF);
      check("t1_en_off", 64'(bus_a.mem_en), 64'h0);
      tick();
      @(negedge clk);
      check("t1_busy_low", 64'(bus_a.busy), 64'h0);

      // ls partial write beats fetch; fetch follows two cycles later
      tick();
      bus_a.if_req = 1; bus_a.if_addr = 13'h010;
      bus_a.ls_req = 1; bus_a.ls_we = 4'b0011; bus_a.ls_addr = 13'h020;
      bus_a.ls_wdata = 32'h12345678;
      tick();
      bus_a.ls_req = 0;
      @(negedge clk);
      check("t2_gnts_c1", 64'({bus_a.if_gnt, bus_a.ls_gnt}), 64'b01);
      check("t2_mem_we", 64'(bus_a.mem_we), 64'b0011);
      tick();
      @(negedge clk);
      check("t2_idle_c2", 64'({bus_a.busy, bus_a.owner}), 64'h0);
      tick();
      bus_a.if_req = 0;
      @(negedge clk);
      check("t2_if_gnt_c3", 64'(bus_a.if_gnt), 64'h1);
      tick();
      @(negedge clk);
      check("t2_if_rdata", 64'(bus_a.rdata), 64'hDEADBEEF);
      check("t2_mem_word", 64'(mem_a[32]), 64'hAABB5678);

      // dbg write beats ls read of the same word
      tick();
      bus_a.dbg_req = 1; bus_a.dbg_we = 4'hF; bus_a.dbg_addr = 13'h030;
      bus_a.dbg_wdata = 32'hCAFEF00D;
      bus_a.ls_req = 1; bus_a.ls_we = '0; bus_a.ls_addr = 13'h030;
      tick();
      bus_a.dbg_req = 0;
      @(negedge clk);
      check("t3_dbg_gnt", 64'({bus_a.dbg_gnt, bus_a.ls_gnt}), 64'b10);
      check("t3_owner_c1", 64'(bus_a.owner), 64'h3);
      tick();
      @(negedge clk);
      check("t3_owner_c2", 64'(bus_a.owner), 64'h0);
      tick();
      bus_a.ls_req = 0;
      @(negedge clk);
      check("t3_ls_gnt", 64'(bus_a.ls_gnt), 64'h1);
      check("t3_owner_c3", 64'(bus_a.owner), 64'h2);
      tick();
      @(negedge clk);
      check("t3_ls_rdata", 64'({bus_a.ls_rvalid, bus_a.rdata}), {31'h0, 1'b1, 32'hCAFEF00D});

      // Continuous ls reads starve fetch until the counter saturates
      tick();
      bus_a.ls_req = 1; bus_a.ls_we = '0; bus_a.ls_addr = 13'h030;
      bus_a.if_req = 1; bus_a.if_addr = 13'h010;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) tick();
         if (c == 10) begin
            bus_a.if_req = 0;
            bus_a.ls_req = 0;
         end
         @(negedge clk);
         check($sformatf("t4_gnts_c%0d", c), 64'({bus_a.if_gnt, bus_a.ls_gnt}),
               64'({c == 10, c == 1 || c == 4 || c == 7}));
         if (c == 9)  check("t4_starve_sat", 64'(dut_a.starve_cnt), 64'h8);
         if (c == 10) check("t4_starve_clr", 64'(dut_a.starve_cnt), 64'h0);
      end
      tick();
      @(negedge clk);
      check("t4_if_rvalid", 64'(bus_a.if_rvalid), 64'h1);

      // Latency-3 ls read on instance b
      tick();
      bus_b.ls_req = 1; bus_b.ls_we = '0; bus_b.ls_addr = 13'h040;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) bus_b.ls_req = 0;
         @(negedge clk);
         check($sformatf("t5_c%0d", c),
               64'({bus_b.ls_gnt, bus_b.mem_en, bus_b.ls_rvalid, bus_b.busy}),
               64'({c == 1, c == 1, c == 4, c >= 1 && c <= 4}));
         if (c == 4) check("t5_rdata", 64'(bus_b.rdata), 64'h0BADF00D);
      end

      // Reset in the middle of a dbg read's wait phase
      tick();
      bus_b.dbg_req = 1; bus_b.dbg_we = '0; bus_b.dbg_addr = 13'h040;
      bus_b.dbg_wdata = 32'h11223344;
      tick();
      bus_b.dbg_req = 0;
      @(negedge clk);
      check("t6_dbg_gnt", 64'(bus_b.dbg_gnt), 64'h1);
      tick();
      @(negedge clk);
      check("t6_wait", 64'({bus_b.busy, bus_b.mem_en}), 64'b10);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_outs", 64'(outs_b()), 64'h0);
      check("t6_async_bus", 64'({bus_b.mem_addr, bus_b.mem_wdata}), 64'h0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("t6_quiet_%0d", c), 64'({bus_b.dbg_rvalid, bus_b.busy}), 64'h0);
         tick();
      end
      bus_b.if_req = 1; bus_b.if_addr = 13'h040;
      tick();
      bus_b.if_req = 0;
      @(negedge clk);
      check("t6_if_gnt", 64'(bus_b.if_gnt), 64'h1);
      repeat (3) tick();
      @(negedge clk);
      check("t6_if_read", 64'({bus_b.if_rvalid, bus_b.rdata}), {31'h0, 1'b1, 32'h0BADF00D});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
